// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Next-PC predictor for the 5-stage RV32 pipeline. A direct-mapped BTB holds
// {valid, tag, target, is_cond}. A separate table of saturating counters
// gives the direction for conditional branches. The counter index is either
// the PC (bimodal) or the PC XOR global history (gshare).
// IF reads the tables combinationally. EX writes the resolved outcome back
// and raises the mispredict/recovery signals.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low
//   lookup_en        IF is advancing this cycle
//   pc_if            fetch PC
//   pred_taken_if    predicted redirect
//   pred_target_if   predicted next PC (BTB target or pc_if+4)
//   ghr_if           history snapshot that travels with the instruction
//   upd_valid        resolved instruction present in EX
//   upd_pc           PC of the resolved instruction
//   upd_is_branch    conditional branch
//   upd_is_jump      JAL / JALR
//   upd_taken        actual direction
//   upd_target       actual target
//   upd_pred_taken   prediction carried down the pipe
//   upd_pred_target  predicted target carried down the pipe
//   upd_ghr          history snapshot carried down the pipe
//   mispredict       flush IF/ID and redirect
//   recover_pc       correct next PC
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 0,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookup_en,
  input  logic [XLEN-1:0]     pc_if,
  output logic                pred_taken_if,
  output logic [XLEN-1:0]     pred_target_if,
  output logic [GHR_BITS-1:0] ghr_if,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic                upd_pred_taken,
  input  logic [XLEN-1:0]     upd_pred_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  output logic                mispredict,
  output logic [XLEN-1:0]     recover_pc
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  // Lookup is zero-latency, so the tag/target arrays are distributed RAM
  // with an asynchronous read. Only valid, is_cond and the counters need reset.
  logic [TAG_W-1:0]    tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];
  logic [ENTRIES-1:0]  valid_reg;
  logic [ENTRIES-1:0]  cond_reg;
  logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];
  logic [GHR_BITS-1:0] ghr_reg;
  logic [GHR_BITS-1:0] ghr_next;

  // The counter index folds in the history only in gshare mode.
  // The history is zero-extended up to the index width.
  function automatic logic [IDX-1:0] ctr_index(input logic [XLEN-1:0]     pc,
                                               input logic [GHR_BITS-1:0] g);
    if (MODE == 1) return pc[IDX+1:2] ^ IDX'(g);
    else           return pc[IDX+1:2];
  endfunction

  // ---------------- lookup ----------------
  logic [IDX-1:0] lk_bidx;
  logic [IDX-1:0] lk_cidx;
  logic           lk_hit;
  logic           lk_cond;

  assign lk_bidx = pc_if[IDX+1:2];
  assign lk_cidx = ctr_index(pc_if, ghr_reg);
  assign lk_hit  = valid_reg[lk_bidx] && (tag_mem[lk_bidx] == pc_if[XLEN-1:IDX+2]);
  assign lk_cond = cond_reg[lk_bidx];

  // Jumps in the BTB are always taken. Branches follow the counter MSB.
  assign pred_taken_if  = lk_hit && (!lk_cond || ctr_reg[lk_cidx][CTR_BITS-1]);
  assign pred_target_if = pred_taken_if ? target_mem[lk_bidx] : pc_if + XLEN'(4);
  assign ghr_if         = (MODE == 1) ? ghr_reg : '0;

  // ---------------- resolution ----------------
  logic eff_taken;

  assign eff_taken  = upd_taken && (upd_is_branch || upd_is_jump);
  assign mispredict = upd_valid &&
                      ((eff_taken != upd_pred_taken) ||
                       (eff_taken && (upd_target != upd_pred_target)));
  assign recover_pc = eff_taken ? upd_target : upd_pc + XLEN'(4);

  // ---------------- update decode ----------------
  logic [IDX-1:0]      up_bidx;
  logic [IDX-1:0]      up_cidx;
  logic                up_tag_hit;
  logic                btb_write;
  logic                stale_clear;
  logic                ctr_write;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_upd;

  assign up_bidx    = upd_pc[IDX+1:2];
  assign up_cidx    = ctr_index(upd_pc, upd_ghr);
  assign up_tag_hit = tag_mem[up_bidx] == upd_pc[XLEN-1:IDX+2];
  assign btb_write  = upd_valid && eff_taken;
  assign ctr_write  = upd_valid && upd_is_branch;
  // A non-control instruction predicted taken means the BTB entry is stale.
  // This happens, for example, after code is overwritten. Drop the entry only if it is really ours.
  assign stale_clear = upd_valid && !upd_is_branch && !upd_is_jump &&
                       upd_pred_taken && up_tag_hit;

  assign ctr_cur = ctr_reg[up_cidx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_BITS'(1);
    end
  end

  // ---------------- global history ----------------
  logic [GHR_BITS:0]   spec_cat;
  logic [GHR_BITS:0]   rec_cat;
  logic [GHR_BITS-1:0] ghr_spec;
  logic [GHR_BITS-1:0] ghr_recover;

  // Shift-in via a one-bit-wider concatenation keeps GHR_BITS=1 legal.
  assign spec_cat    = {ghr_reg, pred_taken_if};
  assign rec_cat     = {upd_ghr, upd_taken};
  assign ghr_spec    = spec_cat[GHR_BITS-1:0];
  assign ghr_recover = upd_is_branch ? rec_cat[GHR_BITS-1:0] : upd_ghr;

  always_comb begin
    ghr_next = ghr_reg;
    if (MODE == 1) begin
      // A repair from EX outranks the speculative shift from IF.
      if (mispredict)
        ghr_next = ghr_recover;
      else if (lookup_en && lk_hit && lk_cond)
        ghr_next = ghr_spec;
    end else begin
      ghr_next = '0;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      cond_reg  <= '0;
      ghr_reg   <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= CTR_INIT;
    end else begin
      if (ctr_write) ctr_reg[up_cidx] <= ctr_upd;
      if (btb_write) begin
        valid_reg[up_bidx] <= 1'b1;
        cond_reg[up_bidx]  <= upd_is_branch;
      end else if (stale_clear) begin
        valid_reg[up_bidx] <= 1'b0;
      end
      ghr_reg <= ghr_next;
    end
  end

  // Tag and target carry no reset. The valid bits decide whether they are used.
  // Writes are held off while reset is low, so an update caught by reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (btb_write && reset) begin
      tag_mem[up_bidx]    <= upd_pc[XLEN-1:IDX+2];
      target_mem[up_bidx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Scoreboard bench for branch_predictor. The bench pushes expected output
// values when it drives a cycle's stimulus. After the combinational outputs
// settle, it pops each entry and compares it with the DUT.
// Two instances are used: bimodal (MODE=0) and gshare (MODE=1, GHR_BITS=4).
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // bimodal instance
  logic        lookup_en, pred_taken_if, upd_valid, upd_is_branch, upd_is_jump;
  logic        upd_taken, upd_pred_taken, mispredict;
  logic [31:0] pc_if, pred_target_if, upd_pc, upd_target, upd_pred_target, recover_pc;
  logic [5:0]  ghr_if, upd_ghr;

  // gshare instance
  logic        g_lookup_en, g_pred_taken_if, g_upd_valid, g_upd_is_branch, g_upd_is_jump;
  logic        g_upd_taken, g_upd_pred_taken, g_mispredict;
  logic [31:0] g_pc_if, g_pred_target_if, g_upd_pc, g_upd_target, g_upd_pred_target, g_recover_pc;
  logic [3:0]  g_ghr_if, g_upd_ghr;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .MODE(0), .GHR_BITS(6)) dut (
    .clk(clk), .reset(reset), .lookup_en(lookup_en), .pc_if(pc_if),
    .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if), .ghr_if(ghr_if),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mispredict), .recover_pc(recover_pc)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .MODE(1), .GHR_BITS(4)) dut_g (
    .clk(clk), .reset(reset), .lookup_en(g_lookup_en), .pc_if(g_pc_if),
    .pred_taken_if(g_pred_taken_if), .pred_target_if(g_pred_target_if), .ghr_if(g_ghr_if),
    .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_is_branch(g_upd_is_branch),
    .upd_is_jump(g_upd_is_jump), .upd_taken(g_upd_taken), .upd_target(g_upd_target),
    .upd_pred_taken(g_upd_pred_taken), .upd_pred_target(g_upd_pred_target), .upd_ghr(g_upd_ghr),
    .mispredict(g_mispredict), .recover_pc(g_recover_pc)
  );

  // Output selectors: 0..4 bimodal, 10..14 gshare
  localparam int S_PT = 0, S_TGT = 1, S_GHR = 2, S_MIS = 3, S_REC = 4, G = 10;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   txn       = 0;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      S_PT:      return {31'b0, pred_taken_if};
      S_TGT:     return pred_target_if;
      S_GHR:     return {26'b0, ghr_if};
      S_MIS:     return {31'b0, mispredict};
      S_REC:     return recover_pc;
      G + S_PT:  return {31'b0, g_pred_taken_if};
      G + S_TGT: return g_pred_target_if;
      G + S_GHR: return {28'b0, g_ghr_if};
      G + S_MIS: return {31'b0, g_mispredict};
      G + S_REC: return g_recover_pc;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    lookup_en = 0; pc_if = 0; upd_valid = 0; upd_pc = 0; upd_is_branch = 0;
    upd_is_jump = 0; upd_taken = 0; upd_target = 0; upd_pred_taken = 0;
    upd_pred_target = 0; upd_ghr = 0;
    g_lookup_en = 0; g_pc_if = 0; g_upd_valid = 0; g_upd_pc = 0; g_upd_is_branch = 0;
    g_upd_is_jump = 0; g_upd_taken = 0; g_upd_target = 0; g_upd_pred_taken = 0;
    g_upd_pred_target = 0; g_upd_ghr = 0;
  endtask

  task automatic upd_a(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt; upd_ghr = 0;
  endtask

  task automatic upd_g(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic [3:0] gh);
    g_upd_valid = 1; g_upd_pc = pc; g_upd_is_branch = br; g_upd_is_jump = jmp; g_upd_taken = tk;
    g_upd_target = tgt; g_upd_pred_taken = ptk; g_upd_pred_target = ptgt; g_upd_ghr = gh;
  endtask

  // Inputs are driven at the falling edge. Outputs are checked 1 ns later, and
  // the rising edge in between commits the update.
  task automatic cyc();
    int n;
    exp_t e;
    #1;
    n = sb.size();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.name, obs_of(e.sel), e.exp);
    end
    txn++;
    $display("txn %0d t=%0t pc_if=%08h g_pc_if=%08h upd=%0b g_upd=%0b compared=%0d",
             txn, $time, pc_if, g_pc_if, upd_valid, g_upd_valid, n);
    @(negedge clk);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time 100000 reached, expected finish before");
    $fatal(1);
  end

  initial begin
    reset = 0;
    idle();
    @(negedge clk);

    // Outputs while reset is held.
    pc_if = 32'h100; g_pc_if = 32'h100;
    push("rst_pt", S_PT, 0); push("rst_tgt", S_TGT, 32'h104);
    push("rst_ghr", S_GHR, 0); push("rst_mis", S_MIS, 0);
    push("rst_g_ghr", G + S_GHR, 0); push("rst_g_pt", G + S_PT, 0);
    cyc();
    reset = 1;

    // Taken branch at 0x100 -> 0x80, predicted not-taken. No same-cycle bypass.
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    push("nobypass_pt", S_PT, 0); push("nobypass_tgt", S_TGT, 32'h104);
    push("tk_mis", S_MIS, 1); push("tk_rec", S_REC, 32'h80);
    cyc();
    pc_if = 32'h100;
    push("hit_pt", S_PT, 1); push("hit_tgt", S_TGT, 32'h80); push("idle_mis", S_MIS, 0);
    cyc();
    // Correctly predicted taken branch -> counter 11.
    upd_a(32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    push("ok_mis", S_MIS, 0); push("ok_rec", S_REC, 32'h80);
    cyc();
    // Two not-taken resolutions: 11 -> 10 -> 01.
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    push("c11_pt", S_PT, 1); push("nt1_mis", S_MIS, 1); push("nt1_rec", S_REC, 32'h104);
    cyc();
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    push("c10_pt", S_PT, 1); push("c10_tgt", S_TGT, 32'h80);
    push("nt2_mis", S_MIS, 1); push("nt2_rec", S_REC, 32'h104);
    cyc();
    pc_if = 32'h100;
    push("c01_pt", S_PT, 0); push("c01_tgt", S_TGT, 32'h104);
    cyc();

    // Four taken updates from 01 saturate at 11.
    for (int i = 0; i < 4; i++) begin
      upd_a(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      push("sat_mis", S_MIS, 1); push("sat_rec", S_REC, 32'h80);
      cyc();
    end
    upd_a(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    cyc();
    // 11 -> 10 must still predict taken.
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    push("sathi_pt", S_PT, 1); push("sathi_tgt", S_TGT, 32'h80);
    cyc();
    // 01, then down to 00 twice (saturate), then up to 01.
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    push("c01b_pt", S_PT, 0);
    cyc();
    upd_a(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
    push("nt_ok_mis", S_MIS, 0); push("nt_ok_rec", S_REC, 32'h104);
    cyc();
    upd_a(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    cyc();
    pc_if = 32'h100; upd_a(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    push("satlo_pt", S_PT, 0);
    cyc();
    pc_if = 32'h100;
    push("c10b_pt", S_PT, 1);
    cyc();

    // Aliasing: JAL 0x100 -> 0x400, then JAL 0x200 -> 0x500 (same index).
    upd_a(32'h100, 0, 1, 1, 32'h400, 0, 32'h104);
    push("jal1_mis", S_MIS, 1); push("jal1_rec", S_REC, 32'h400);
    cyc();
    pc_if = 32'h100;
    push("jal1_pt", S_PT, 1); push("jal1_tgt", S_TGT, 32'h400);
    cyc();
    upd_a(32'h200, 0, 1, 1, 32'h500, 0, 32'h204);
    push("jal2_mis", S_MIS, 1); push("jal2_rec", S_REC, 32'h500);
    cyc();
    pc_if = 32'h100;
    push("alias_pt", S_PT, 0); push("alias_tgt", S_TGT, 32'h104);
    cyc();
    pc_if = 32'h200;
    push("jal2_pt", S_PT, 1); push("jal2_tgt", S_TGT, 32'h500);
    cyc();

    // Stale entry: non-control predicted taken. upd_taken must be ignored.
    upd_a(32'h200, 0, 0, 1, 32'h999, 1, 32'h500);
    push("stale_mis", S_MIS, 1); push("stale_rec", S_REC, 32'h204);
    cyc();
    pc_if = 32'h200;
    push("stale_pt", S_PT, 0); push("stale_tgt", S_TGT, 32'h204);
    cyc();

    // Right direction, wrong target.
    upd_a(32'h300, 0, 1, 1, 32'h600, 1, 32'h700);
    push("tgt_mis", S_MIS, 1); push("tgt_rec", S_REC, 32'h600);
    cyc();
    pc_if = 32'h300;
    push("jalr_pt", S_PT, 1); push("jalr_tgt", S_TGT, 32'h600);
    cyc();
    // Plain instruction, not predicted: no mispredict.
    upd_a(32'h304, 0, 0, 1, 32'h999, 0, 32'h308);
    push("plain_mis", S_MIS, 0); push("plain_rec", S_REC, 32'h308);
    cyc();
    // pc+4 wraps modulo 2^32.
    pc_if = 32'hFFFF_FFFC;
    push("wrap_pt", S_PT, 0); push("wrap_tgt", S_TGT, 32'h0);
    cyc();

    // ---------------- gshare, GHR_BITS=4 ----------------
    // Train branch 0x40 -> 0x800 under history 0101 (correctly predicted).
    upd_g(32'h40, 1, 0, 1, 32'h800, 1, 32'h800, 4'b0101);
    push("g_train_mis", G + S_MIS, 0); push("g_train_rec", G + S_REC, 32'h800);
    cyc();
    // A mispredicted jump restores the history to its snapshot, 0101.
    upd_g(32'h1000, 0, 1, 1, 32'h1200, 0, 32'h1004, 4'b0101);
    push("g_jmp_mis", G + S_MIS, 1); push("g_jmp_rec", G + S_REC, 32'h1200);
    push("g_ghr0", G + S_GHR, 0);
    cyc();
    // Predicted-taken conditional hit with lookup_en shifts 0101 -> 1011.
    g_lookup_en = 1; g_pc_if = 32'h40;
    push("g_ghr_0101", G + S_GHR, 4'b0101); push("g_pt", G + S_PT, 1);
    push("g_tgt", G + S_TGT, 32'h800);
    cyc();
    upd_g(32'h1000, 0, 1, 1, 32'h1200, 0, 32'h1004, 4'b0101);
    push("g_spec_ghr", G + S_GHR, 4'b1011);
    cyc();
    // Mispredict and speculative shift in the same cycle: the repair wins.
    g_lookup_en = 1; g_pc_if = 32'h40;
    upd_g(32'h2000, 1, 0, 0, 32'h2400, 1, 32'h2400, 4'b0011);
    push("g_ghr_0101b", G + S_GHR, 4'b0101); push("g_pt_b", G + S_PT, 1);
    push("g_rep_mis", G + S_MIS, 1); push("g_rep_rec", G + S_REC, 32'h2004);
    cyc();
    push("g_rep_ghr", G + S_GHR, 4'b0110);
    cyc();

    // ---------------- reset during an update ----------------
    upd_a(32'h300, 1, 0, 1, 32'h900, 0, 32'h304);
    upd_g(32'h40, 1, 0, 1, 32'h900, 0, 32'h44, 4'b0110);
    pc_if = 32'h100;
    reset = 0;
    push("rst2_pt", S_PT, 0); push("rst2_tgt", S_TGT, 32'h104);
    push("rst2_g_ghr", G + S_GHR, 0);
    cyc();
    reset = 1;
    pc_if = 32'h300;
    push("post_pt_300", S_PT, 0); push("post_tgt_300", S_TGT, 32'h304);
    cyc();
    pc_if = 32'h200; g_lookup_en = 1; g_pc_if = 32'h40;
    push("post_pt_200", S_PT, 0); push("post_tgt_200", S_TGT, 32'h204);
    push("post_g_pt", G + S_PT, 0); push("post_g_tgt", G + S_TGT, 32'h44);
    push("post_g_ghr", G + S_GHR, 0);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
